// File: rtl/cache_pkg.sv
// Shared FSM state encoding and default geometry for the cache memory initiator.
package cache_pkg;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_DEPTH   = 1024;
    localparam int DEF_TIMEOUT = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/cache_mem_initiator.sv
// Cache-side memory initiator: word write-through and 4-word block refill with a wait timeout.
// Latency: strobe the cycle after accept, response the cycle after mem_ready; req_ready low until back in IDLE.
module cache_mem_initiator
    import cache_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int TIMEOUT = DEF_TIMEOUT,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    input  logic                 req_write,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [WIDTH-1:0]     req_wdata,
    output logic                 req_ready,
    output logic                 resp_valid,
    output logic                 resp_error,
    output logic [4*WIDTH-1:0]   resp_block,
    output logic [ADDR_W-1:0]    mem_address,
    output logic                 mem_write_en,
    output logic                 mem_read_en,
    output logic [WIDTH-1:0]     mem_write_data,
    input  logic                 mem_ready,
    input  logic [4*WIDTH-1:0]   mem_read_data
);

    localparam int CNT_W = ($clog2(TIMEOUT) + 1 > 8) ? $clog2(TIMEOUT) + 1 : 8;

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  addr_q;
    logic [WIDTH-1:0]   wdata_q;
    logic [CNT_W-1:0]   wait_cnt;
    logic               err_q;
    logic [4*WIDTH-1:0] block_q;
    logic               accept;
    logic               busy;
    logic               timeout_hit;

    assign accept      = (state == ST_IDLE) && req_valid;
    assign busy        = (state == ST_WRITE) || (state == ST_READ);
    assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (req_valid) state_nxt = req_write ? ST_WRITE : ST_READ;
            ST_WRITE,
            ST_READ:  if (mem_ready || timeout_hit) state_nxt = ST_RESP;
            ST_RESP:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // err_q is rewritten every busy cycle; only the value on the exit cycle reaches RESP,
    // so a ready coinciding with the timeout reads as success.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            wait_cnt <= '0;
            err_q    <= 1'b0;
            block_q  <= '0;
        end else begin
            if (accept) begin
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                wait_cnt <= '0;
            end
            if (busy) begin
                err_q <= !mem_ready;
                if (!mem_ready) wait_cnt <= wait_cnt + 1'b1;
            end
            if ((state == ST_READ) && mem_ready) block_q <= mem_read_data;
        end
    end

    always_comb begin
        req_ready      = 1'b0;
        resp_valid     = 1'b0;
        resp_error     = 1'b0;
        mem_address    = '0;
        mem_write_en   = 1'b0;
        mem_read_en    = 1'b0;
        mem_write_data = '0;
        case (state)
            ST_IDLE:  req_ready = 1'b1;
            ST_WRITE: begin
                mem_write_en   = 1'b1;
                mem_address    = addr_q;
                mem_write_data = wdata_q;
            end
            ST_READ: begin
                mem_read_en = 1'b1;
                mem_address = {addr_q[ADDR_W-1:2], 2'b00};
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_error = err_q;
            end
            default: ;
        endcase
    end

    assign resp_block = block_q;

endmodule

// File: tb/tb_cache_mem_initiator.sv
// Directed bench for cache_mem_initiator: write, refill, timeout, back-to-back, reset abort, stray ready.
module tb_cache_mem_initiator;

    localparam int WIDTH = 32;
    localparam int DEPTH = 1024;
    localparam int TIMEOUT = 64;
    localparam int ADDR_W = 10;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                req_valid = 1'b0;
    logic                req_write = 1'b0;
    logic [ADDR_W-1:0]   req_addr = '0;
    logic [WIDTH-1:0]    req_wdata = '0;
    logic                req_ready;
    logic                resp_valid;
    logic                resp_error;
    logic [4*WIDTH-1:0]  resp_block;
    logic [ADDR_W-1:0]   mem_address;
    logic                mem_write_en;
    logic                mem_read_en;
    logic [WIDTH-1:0]    mem_write_data;
    logic                mem_ready = 1'b0;
    logic [4*WIDTH-1:0]  mem_read_data = '0;

    int checks = 0;
    int errors = 0;

    cache_mem_initiator #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_error(resp_error), .resp_block(resp_block),
        .mem_address(mem_address), .mem_write_en(mem_write_en), .mem_read_en(mem_read_en),
        .mem_write_data(mem_write_data), .mem_ready(mem_ready), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issues one request and plays memory: mem_ready rises on strobe cycle index 'delay' (never if negative).
    task automatic run_txn(input bit wr, input logic [ADDR_W-1:0] addr, input logic [WIDTH-1:0] wd,
                           input int delay, input logic [127:0] rdata,
                           output int strobes, output int first_idx, output int resp_idx, output bit err,
                           output logic [ADDR_W-1:0] seen_addr, output logic [WIDTH-1:0] seen_wd,
                           output bit overlap);
        int guard;
        strobes = 0; first_idx = -1; resp_idx = -1; err = 1'b0;
        seen_addr = '0; seen_wd = '0; overlap = 1'b0; guard = 0;
        while (!req_ready && guard < 50) begin
            tick;
            guard++;
        end
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
        tick;
        req_valid = 1'b0; req_write = ~wr; req_addr = ~addr; req_wdata = ~wd;
        for (int c = 0; c < 200; c++) begin
            if (mem_write_en && mem_read_en) overlap = 1'b1;
            if (mem_write_en || mem_read_en) begin
                if (first_idx < 0) first_idx = c;
                seen_addr = mem_address;
                seen_wd = mem_write_data;
                mem_ready = (strobes == delay);
                mem_read_data = rdata;
                strobes++;
            end else begin
                mem_ready = 1'b0;
            end
            if (resp_valid) begin
                resp_idx = c;
                err = resp_error;
                break;
            end
            tick;
        end
        mem_ready = 1'b0;
        mem_read_data = '0;
    endtask

    int                 strobes, first_idx, resp_idx;
    bit                 err, overlap;
    logic [ADDR_W-1:0]  seen_addr;
    logic [WIDTH-1:0]   seen_wd;
    logic [127:0]       refill_blk;
    bit                 any_resp;

    initial begin
        refill_blk = {32'h4, 32'h3, 32'h2, 32'h1};

        // reset state
        #1;
        check("rst_req_ready", 128'(req_ready), 128'd1);
        check("rst_resp", {126'd0, resp_valid, resp_error}, 128'd0);
        check("rst_block", resp_block, 128'd0);
        check("rst_mem", {mem_address, mem_write_data, mem_write_en, mem_read_en}, 128'd0);
        #11 reset = 1'b1;
        tick;

        // write-through, ready after 2 cycles
        run_txn(1'b1, 10'h010, 32'hDEADBEEF, 2, {4{32'hFFFF_FFFF}},
                strobes, first_idx, resp_idx, err, seen_addr, seen_wd, overlap);
        check("wr_strobes", 128'(strobes), 128'd3);
        check("wr_first_strobe", 128'(first_idx), 128'd0);
        check("wr_addr", 128'(seen_addr), 128'h010);
        check("wr_data", 128'(seen_wd), 128'hDEADBEEF);
        check("wr_resp_idx", 128'(resp_idx), 128'd3);
        check("wr_err", 128'(err), 128'd0);
        check("wr_block_kept", resp_block, 128'd0);
        tick;
        check("wr_after", {126'd0, req_ready, resp_valid}, 128'b10);

        // block refill with unaligned address
        run_txn(1'b0, 10'h013, 32'h0, 4, refill_blk,
                strobes, first_idx, resp_idx, err, seen_addr, seen_wd, overlap);
        check("rd_strobes", 128'(strobes), 128'd5);
        check("rd_addr", 128'(seen_addr), 128'h010);
        check("rd_resp_idx", 128'(resp_idx), 128'd5);
        check("rd_err", 128'(err), 128'd0);
        check("rd_block", resp_block, refill_blk);
        tick;

        // timeout: memory never answers
        run_txn(1'b0, 10'h2A5, 32'h0, -1, {4{32'h5A5A_5A5A}},
                strobes, first_idx, resp_idx, err, seen_addr, seen_wd, overlap);
        check("to_strobes", 128'(strobes), 128'd64);
        check("to_resp_idx", 128'(resp_idx), 128'd64);
        check("to_err", 128'(err), 128'd1);
        check("to_block_kept", resp_block, refill_blk);
        tick;
        check("to_after", {126'd0, req_ready, resp_valid}, 128'b10);

        // minimum latency: ready with the first strobe
        run_txn(1'b1, 10'h3FF, 32'h1234_5678, 0, {4{32'h0BAD_0BAD}},
                strobes, first_idx, resp_idx, err, seen_addr, seen_wd, overlap);
        check("min_strobes", 128'(strobes), 128'd1);
        check("min_resp_idx", 128'(resp_idx), 128'd1);
        check("min_block_kept", resp_block, refill_blk);
        tick;
        check("min_ready_n3", {126'd0, req_ready, resp_error}, 128'b10);

        // back-to-back with req_valid held high
        req_valid = 1'b1; req_write = 1'b1; req_addr = 10'h020; req_wdata = 32'hCAFE_0001;
        tick;
        req_write = 1'b0; req_addr = 10'h031;
        mem_ready = 1'b1;
        check("b2b_c1", {mem_write_en, mem_read_en, req_ready, 10'(mem_address), 32'(mem_write_data)},
              {3'b100, 10'h020, 32'hCAFE_0001});
        tick;
        mem_ready = 1'b0;
        check("b2b_c2", {resp_valid, resp_error, req_ready, mem_write_en, mem_read_en}, 5'b10000);
        tick;
        check("b2b_c3", {req_ready, mem_write_en, mem_read_en}, 3'b100);
        tick;
        req_valid = 1'b0;
        mem_ready = 1'b1; mem_read_data = {32'hD, 32'hC, 32'hB, 32'hA};
        check("b2b_c4", {mem_write_en, mem_read_en, req_ready, 10'(mem_address)}, {3'b010, 10'h030});
        tick;
        mem_ready = 1'b0; mem_read_data = '0;
        check("b2b_c5", {resp_valid, resp_error}, 2'b10);
        check("b2b_block", resp_block, {32'hD, 32'hC, 32'hB, 32'hA});
        tick;

        // reset asserted on the third READ cycle
        req_valid = 1'b1; req_write = 1'b0; req_addr = 10'h044;
        tick;
        req_valid = 1'b0;
        tick;
        tick;
        check("rst_mid_in_read", 128'(mem_read_en), 128'd1);
        reset = 1'b0;
        #1;
        check("rst_mid_strobes", {126'd0, mem_read_en, mem_write_en}, 128'd0);
        check("rst_mid_state", {126'd0, req_ready, resp_valid}, 128'b10);
        tick;
        reset = 1'b1;
        any_resp = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick;
            if (resp_valid) any_resp = 1'b1;
        end
        check("rst_mid_no_resp", 128'(any_resp), 128'd0);
        check("rst_mid_ready", 128'(req_ready), 128'd1);

        // stray mem_ready in IDLE
        mem_ready = 1'b1; mem_read_data = {4{32'h7777_7777}};
        tick;
        mem_ready = 1'b0;
        any_resp = resp_valid;
        tick;
        if (resp_valid) any_resp = 1'b1;
        check("stray_no_resp", 128'(any_resp), 128'd0);
        check("stray_idle", {req_ready, mem_write_en, mem_read_en}, 3'b100);
        check("stray_block", resp_block, 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
